regfile_dump_ctrl: RTL and testbench

Debug-unit sequencer that takes over the register file's rs read port and streams all registers out as bytes to the UART TX path.
- In IDLE the port is transparent: the pipeline's rs address passes straight through.
- On a start request it stalls the pipeline, walks addresses 0..NUM_REGS-1, and serialises each 32-bit word MSB-byte first over a valid/ready byte handshake.
- Sits between the pipeline decode stage, the register file and the debug UART transmitter.

---
 rtl/regfile_dump_ctrl.sv | 110 +++++++++++
 tb/tb_regfile_dump_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: borrows the register file rs read port and streams every register
// out as bytes, MSB first, over a valid/ready handshake to the debug UART transmitter.
module regfile_dump_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BYTE_W   = 8
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_dump_start,
    input  logic [ADDR_W-1:0] i_pipe_addr_rs,
    input  logic [DATA_W-1:0] i_rf_data_rs,
    input  logic              i_tx_ready,
    output logic [ADDR_W-1:0] o_rf_addr_rs,
    output logic              o_pipe_stall,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned NumBytes = DATA_W / BYTE_W;
    localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    localparam logic [CntW-1:0]   LastByte = CntW'(NumBytes - 1);
    localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        o_tx_valid = 1'b0;
        o_tx_data  = '0;
        o_done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_dump_start) begin
                    ptr_d   = '0;
                    state_d = StRead;
                end
            end

            // Register file output for ptr_q settles on negedge, so it is valid at this edge.
            StRead: begin
                shift_d    = i_rf_data_rs;
                byte_cnt_d = '0;
                state_d    = StSend;
            end

            StSend: begin
                o_tx_valid = 1'b1;
                o_tx_data  = shift_q[DATA_W-1 -: BYTE_W];
                if (i_tx_ready) begin
                    shift_d    = shift_q << BYTE_W;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LastByte) begin
                        if (ptr_q == LastPtr) begin
                            state_d = StDone;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = StRead;
                        end
                    end
                end
            end

            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    // Outside a dump the rs port is transparent to the pipeline.
    assign o_rf_addr_rs = (state_q == StIdle) ? i_pipe_addr_rs : ptr_q;
    assign o_busy       = (state_q != StIdle);
    assign o_pipe_stall = o_busy;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a negedge-read register file model.
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_dump_start;
    logic [4:0]  i_pipe_addr_rs;
    logic [31:0] i_rf_data_rs;
    logic        i_tx_ready;
    logic [4:0]  o_rf_addr_rs;
    logic        o_pipe_stall;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic        o_done;

    always #5 clk = ~clk;

    regfile_dump_ctrl #(
        .NUM_REGS(32),
        .ADDR_W  (5),
        .DATA_W  (32),
        .BYTE_W  (8)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_dump_start  (i_dump_start),
        .i_pipe_addr_rs(i_pipe_addr_rs),
        .i_rf_data_rs  (i_rf_data_rs),
        .i_tx_ready    (i_tx_ready),
        .o_rf_addr_rs  (o_rf_addr_rs),
        .o_pipe_stall  (o_pipe_stall),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    logic [31:0] regs [32];

    always @(negedge clk) i_rf_data_rs <= regs[o_rf_addr_rs];

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  got_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Starts a dump in the current cycle and returns one cycle after o_done (already in IDLE).
    task automatic dump(input bit bp, input int extra_start, output int done_cyc,
                        output int done_cnt);
        int         wait_n;
        bit         held;
        logic [7:0] held_b;
        wait_n   = 0;
        held     = 1'b0;
        held_b   = 8'h00;
        done_cyc = -1;
        done_cnt = 0;
        got_q.delete();
        check("idle_before_start", 32'(o_busy), 32'h0);
        i_pipe_addr_rs = 5'd17;
        i_dump_start   = 1'b1;
        i_tx_ready     = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            next_cycle();
            i_dump_start = (c == extra_start);
            if (bp && o_tx_valid) begin
                if (wait_n < 3) begin
                    i_tx_ready = 1'b0;
                    wait_n++;
                end else begin
                    i_tx_ready = 1'b1;
                    wait_n = 0;
                end
            end else begin
                i_tx_ready = 1'b1;
            end
            #1;
            if (c == 1) check("read_addr_reg0", 32'(o_rf_addr_rs), 32'h0);
            if (held && o_tx_valid) check("hold_stable", 32'(o_tx_data), 32'(held_b));
            held   = o_tx_valid && !i_tx_ready;
            held_b = o_tx_data;
            if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check("done_no_valid", 32'({o_tx_valid, o_busy}), 32'h1);
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                check("busy_drop", 32'({o_busy, o_pipe_stall}), 32'h0);
                break;
            end
        end
        i_dump_start = 1'b0;
        if (done_cyc < 0) check("dump_timeout", 32'h0, 32'h1);
    endtask

    task automatic check_stream(input string tag);
        logic [31:0] w;
        check({tag, "_count"}, 32'(got_q.size()), 32'd128);
        for (int i = 0; i < 128 && i < got_q.size(); i++) begin
            w = regs[i / 4] >> (8 * (3 - (i % 4)));
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(w[7:0]));
        end
    endtask

    initial begin
        int  dc;
        int  dn;
        int  nb;
        bit  hit;
        for (int k = 0; k < 32; k++) regs[k] = 32'h01010101 * k;
        i_reset        = 1'b1;
        i_dump_start   = 1'b0;
        i_pipe_addr_rs = 5'd0;
        i_tx_ready     = 1'b1;

        // Reset state
        next_cycle();
        next_cycle();
        #1;
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_stall", 32'(o_pipe_stall), 32'h0);
        check("rst_valid", 32'(o_tx_valid), 32'h0);
        check("rst_data", 32'(o_tx_data), 32'h0);
        check("rst_done", 32'(o_done), 32'h0);
        i_reset = 1'b0;

        // Passthrough in IDLE
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            i_pipe_addr_rs = 5'(a);
            #1;
            check($sformatf("pass_addr%0d", a), 32'(o_rf_addr_rs), 32'(a));
            check("pass_stall_valid", 32'({o_pipe_stall, o_tx_valid}), 32'h0);
        end

        // Full dump, then back-to-back second dump starting the cycle after o_done
        next_cycle();
        dump(1'b0, -1, dc, dn);
        check("full_done_cyc", 32'(dc), 32'd161);
        check("full_done_cnt", 32'(dn), 32'd1);
        check_stream("full");
        dump(1'b0, -1, dc, dn);
        check("b2b_done_cyc", 32'(dc), 32'd161);
        check("b2b_done_cnt", 32'(dn), 32'd1);
        check_stream("b2b");

        // Start pulse while busy is ignored
        next_cycle();
        dump(1'b0, 40, dc, dn);
        check("busy_start_done_cyc", 32'(dc), 32'd161);
        check("busy_start_done_cnt", 32'(dn), 32'd1);
        check_stream("busy_start");
        next_cycle();
        #1;
        check("busy_start_no_restart", 32'(o_busy), 32'h0);

        // Backpressure
        regs[0] = 32'hDEADBEEF;
        next_cycle();
        dump(1'b1, -1, dc, dn);
        check("bp_done_cnt", 32'(dn), 32'd1);
        check("bp_b0", 32'(got_q[0]), 32'hDE);
        check("bp_b1", 32'(got_q[1]), 32'hAD);
        check("bp_b2", 32'(got_q[2]), 32'hBE);
        check("bp_b3", 32'(got_q[3]), 32'hEF);
        check_stream("bp");

        // Reset during SEND of reg 7 byte 2
        next_cycle();
        i_dump_start = 1'b1;
        i_tx_ready   = 1'b1;
        nb  = 0;
        hit = 1'b0;
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            i_dump_start = 1'b0;
            #1;
            if (o_tx_valid) begin
                if (nb == 30) begin
                    check("pre_reset_byte", 32'(o_tx_data), 32'h07);
                    i_reset = 1'b1;
                    hit = 1'b1;
                    break;
                end
                nb++;
            end
        end
        check("reset_point_reached", 32'(hit), 32'h1);
        next_cycle();
        i_reset = 1'b0;
        #1;
        check("mid_rst_idle", 32'({o_busy, o_pipe_stall, o_tx_valid, o_done}), 32'h0);
        check("mid_rst_data", 32'(o_tx_data), 32'h0);
        dump(1'b0, -1, dc, dn);
        check("after_rst_first", 32'(got_q[0]), 32'hDE);
        check("after_rst_done_cyc", 32'(dc), 32'd161);
        check_stream("after_rst");

        // Reset wins over a simultaneous start
        next_cycle();
        i_reset      = 1'b1;
        i_dump_start = 1'b1;
        next_cycle();
        i_reset      = 1'b0;
        i_dump_start = 1'b0;
        #1;
        check("reset_wins", 32'({o_busy, o_tx_valid}), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
